// File: rtl/instruction_fetch.sv
// Fetch stage: holds the PC, fetches words over a req/ack handshake, computes next PC.
// Optional misaligned-target trap enabled by defining IFETCH_MISALIGN_TRAP_EN.
module instruction_fetch #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int unsigned IMEM_AW  = 14
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               Branch,
    input  logic               Zero,
    input  logic               Jal,
    input  logic               Jalr,
    input  logic [31:0]        imm32,
    input  logic [31:0]        rs1_data,
    input  logic               stall,
    output logic               imem_req,
    output logic [IMEM_AW-1:0] imem_addr,
    input  logic               imem_ack,
    input  logic [31:0]        imem_rdata,
    output logic [31:0]        inst,
    output logic [6:0]         opcode,
    output logic               inst_valid,
    output logic [31:0]        pc,
    output logic [31:0]        pc_plus4,
    output logic               misalign
);

    localparam logic [31:0] NopInst = 32'h0000_0013;

    typedef enum logic [1:0] {StBoot, StFetch, StIssue, StHalt} state_e;

    state_e      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] inst_q, inst_d;
    logic        req_q, req_d;
    logic        valid_q, valid_d;

    logic [31:0] jalr_tgt;
    logic [31:0] rel_tgt;
    logic [31:0] next_pc_raw;
    logic [31:0] next_pc;
    logic        tgt_misaligned;

    assign pc_plus4 = pc_q + 32'd4;
    assign jalr_tgt = (rs1_data + imm32) & ~32'h1;
    assign rel_tgt  = pc_q + imm32;

    // Jalr beats Jal; Branch only counts when neither jump is set.
    always_comb begin
        if (Jalr) begin
            next_pc_raw = jalr_tgt;
        end else if (Jal) begin
            next_pc_raw = rel_tgt;
        end else if (Branch && Zero) begin
            next_pc_raw = rel_tgt;
        end else begin
            next_pc_raw = pc_plus4;
        end
    end

`ifdef IFETCH_MISALIGN_TRAP_EN
    logic misalign_q, misalign_d;

    assign next_pc        = next_pc_raw;
    assign tgt_misaligned = |next_pc_raw[1:0];
    assign misalign       = misalign_q;
`else
    assign next_pc        = {next_pc_raw[31:2], 2'b00};
    assign tgt_misaligned = 1'b0;
    assign misalign       = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        inst_d  = inst_q;
        req_d   = 1'b0;
        valid_d = 1'b0;
`ifdef IFETCH_MISALIGN_TRAP_EN
        misalign_d = misalign_q;
`endif
        case (state_q)
            StBoot: begin
                state_d = StFetch;
                req_d   = 1'b1;
            end
            StFetch: begin
                if (imem_ack) begin
                    inst_d  = imem_rdata;
                    state_d = StIssue;
                    valid_d = 1'b1;
                end else begin
                    req_d = 1'b1;
                end
            end
            StIssue: begin
                if (stall) begin
                    valid_d = 1'b1;
                end else if (tgt_misaligned) begin
                    state_d = StHalt;
`ifdef IFETCH_MISALIGN_TRAP_EN
                    misalign_d = 1'b1;
`endif
                end else begin
                    pc_d    = next_pc;
                    state_d = StFetch;
                    req_d   = 1'b1;
                end
            end
            StHalt: begin
                state_d = StHalt;
            end
            default: begin
                state_d = StBoot;
            end
        endcase
    end

    // Outputs are registered alongside the state so they always match it.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= StBoot;
            pc_q    <= RESET_PC;
            inst_q  <= NopInst;
            req_q   <= 1'b0;
            valid_q <= 1'b0;
`ifdef IFETCH_MISALIGN_TRAP_EN
            misalign_q <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            inst_q  <= inst_d;
            req_q   <= req_d;
            valid_q <= valid_d;
`ifdef IFETCH_MISALIGN_TRAP_EN
            misalign_q <= misalign_d;
`endif
        end
    end

    assign imem_req   = req_q;
    assign imem_addr  = pc_q[IMEM_AW+1:2];
    assign inst       = inst_q;
    assign opcode     = inst_q[6:0];
    assign inst_valid = valid_q;
    assign pc         = pc_q;

endmodule

// File: tb/tb_instruction_fetch.sv
// Directed bench for instruction_fetch: handshake timing, next-PC priority, stall, reset, trap.
module tb_instruction_fetch;

    logic        clock;
    logic        reset;
    logic        Branch, Zero, Jal, Jalr;
    logic [31:0] imm32, rs1_data;
    logic        stall;
    logic        imem_req;
    logic [13:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic [31:0] inst;
    logic [6:0]  opcode;
    logic        inst_valid;
    logic [31:0] pc, pc_plus4;
    logic        misalign;

    int n_checks = 0;
    int n_errors = 0;

    instruction_fetch dut (
        .clock      (clock),
        .reset      (reset),
        .Branch     (Branch),
        .Zero       (Zero),
        .Jal        (Jal),
        .Jalr       (Jalr),
        .imm32      (imm32),
        .rs1_data   (rs1_data),
        .stall      (stall),
        .imem_req   (imem_req),
        .imem_addr  (imem_addr),
        .imem_ack   (imem_ack),
        .imem_rdata (imem_rdata),
        .inst       (inst),
        .opcode     (opcode),
        .inst_valid (inst_valid),
        .pc         (pc),
        .pc_plus4   (pc_plus4),
        .misalign   (misalign)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[24:0], 7'h33};
    endfunction

    task automatic tick();
        @(negedge clock);
    endtask

    // Entered at a negedge with the DUT in FETCH; leaves it sampled in ISSUE.
    task automatic fetch(input int delay, input logic [31:0] exp_pc);
        logic [13:0] exp_addr;
        exp_addr = exp_pc[15:2];
        imem_ack = 1'b0;
        for (int i = 0; i < delay; i++) begin
            check_eq("wait_req", {31'd0, imem_req}, 32'd1);
            check_eq("wait_valid", {31'd0, inst_valid}, 32'd0);
            tick();
        end
        check_eq("fetch_req", {31'd0, imem_req}, 32'd1);
        check_eq("fetch_addr", {18'd0, imem_addr}, {18'd0, exp_addr});
        imem_ack   = 1'b1;
        imem_rdata = mem_word(exp_pc);
        tick();
        imem_ack   = 1'b0;
        imem_rdata = 32'h0;
        check_eq("issue_valid", {31'd0, inst_valid}, 32'd1);
        check_eq("issue_inst", inst, mem_word(exp_pc));
        check_eq("issue_opcode", {25'd0, opcode}, 32'h33);
        check_eq("issue_pc", pc, exp_pc);
        check_eq("issue_req", {31'd0, imem_req}, 32'd0);
    endtask

    task automatic issue_exit(input logic br, input logic z, input logic jl, input logic jr,
                              input logic [31:0] imm, input logic [31:0] rs1,
                              input logic [31:0] exp_next);
        Branch = br; Zero = z; Jal = jl; Jalr = jr; imm32 = imm; rs1_data = rs1;
        tick();
        Branch = 1'b0; Zero = 1'b0; Jal = 1'b0; Jalr = 1'b0; imm32 = 32'h0; rs1_data = 32'h0;
        check_eq("next_pc", pc, exp_next);
        check_eq("next_req", {31'd0, imem_req}, 32'd1);
        check_eq("next_valid", {31'd0, inst_valid}, 32'd0);
        check_eq("next_misalign", {31'd0, misalign}, 32'd0);
    endtask

    initial begin
        reset = 1'b1;
        Branch = 1'b0; Zero = 1'b0; Jal = 1'b0; Jalr = 1'b0;
        imm32 = 32'h0; rs1_data = 32'h0; stall = 1'b0;
        imem_ack = 1'b1;
        imem_rdata = mem_word(32'h0);
        repeat (2) @(posedge clock);
        tick();
        check_eq("rst_pc", pc, 32'h0);
        check_eq("rst_inst", inst, 32'h0000_0013);
        check_eq("rst_valid", {31'd0, inst_valid}, 32'd0);
        check_eq("rst_req", {31'd0, imem_req}, 32'd0);
        check_eq("rst_misalign", {31'd0, misalign}, 32'd0);

        // Release with ack held high: FETCH after BOOT, immediate ack.
        reset = 1'b0;
        tick();
        check_eq("boot1_req", {31'd0, imem_req}, 32'd1);
        check_eq("boot1_addr", {18'd0, imem_addr}, 32'd0);
        check_eq("boot1_valid", {31'd0, inst_valid}, 32'd0);
        tick();
        imem_ack = 1'b0;
        check_eq("first_valid", {31'd0, inst_valid}, 32'd1);
        check_eq("first_inst", inst, mem_word(32'h0));
        check_eq("first_pc", pc, 32'h0);
        check_eq("first_pc4", pc_plus4, 32'h4);

        // Sequential fetch with 2-cycle ack delay.
        issue_exit(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 32'h4);
        fetch(2, 32'h4);
        issue_exit(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 32'h8);
        fetch(2, 32'h8);
        issue_exit(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 32'hC);
        fetch(0, 32'hC);
        issue_exit(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 32'h10);
        fetch(0, 32'h10);

        // Branch taken / not taken, Branch+Jal.
        issue_exit(1'b1, 1'b1, 1'b0, 1'b0, 32'hFFFF_FFF8, 32'h0, 32'h8);
        fetch(0, 32'h8);
        issue_exit(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 32'hC);
        fetch(0, 32'hC);
        issue_exit(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 32'h10);
        fetch(1, 32'h10);
        issue_exit(1'b1, 1'b0, 1'b0, 1'b0, 32'hFFFF_FFF8, 32'h0, 32'h14);
        fetch(0, 32'h14);
        issue_exit(1'b0, 1'b0, 1'b1, 1'b0, 32'hFFFF_FFFC, 32'h0, 32'h10);
        fetch(0, 32'h10);
        issue_exit(1'b1, 1'b1, 1'b1, 1'b0, 32'h20, 32'h0, 32'h30);
        fetch(0, 32'h30);
        issue_exit(1'b0, 1'b0, 1'b1, 1'b0, 32'h10, 32'h0, 32'h40);
        fetch(0, 32'h40);

        // Jalr clears bit 0; Jalr beats Jal; wrap at top of address space.
        check_eq("jalr_pc4", pc_plus4, 32'h44);
        issue_exit(1'b0, 1'b0, 1'b0, 1'b1, 32'h4, 32'h101, 32'h104);
        fetch(0, 32'h104);
        issue_exit(1'b1, 1'b1, 1'b1, 1'b1, 32'h8, 32'h200, 32'h208);
        fetch(0, 32'h208);
        issue_exit(1'b0, 1'b0, 1'b0, 1'b1, 32'hC, 32'hFFFF_FFF0, 32'hFFFF_FFFC);
        fetch(0, 32'hFFFF_FFFC);
        check_eq("wrap_pc4", pc_plus4, 32'h0);
        issue_exit(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0);
        fetch(0, 32'h0);

        // Stall in ISSUE freezes everything; stray ack and jump inputs are ignored.
        stall = 1'b1; imem_ack = 1'b1; imem_rdata = 32'hDEAD_BEEF; Jal = 1'b1; imm32 = 32'h40;
        for (int i = 0; i < 3; i++) begin
            tick();
            check_eq("stall_valid", {31'd0, inst_valid}, 32'd1);
            check_eq("stall_pc", pc, 32'h0);
            check_eq("stall_inst", inst, mem_word(32'h0));
            check_eq("stall_req", {31'd0, imem_req}, 32'd0);
        end
        stall = 1'b0; imem_ack = 1'b0; imem_rdata = 32'h0; Jal = 1'b0; imm32 = 32'h0;
        tick();
        check_eq("unstall_req", {31'd0, imem_req}, 32'd1);
        check_eq("unstall_pc", pc, 32'h4);

        // Stall is ignored in FETCH.
        stall = 1'b1; imem_ack = 1'b1; imem_rdata = mem_word(32'h4);
        tick();
        stall = 1'b0; imem_ack = 1'b0; imem_rdata = 32'h0;
        check_eq("fstall_valid", {31'd0, inst_valid}, 32'd1);
        check_eq("fstall_inst", inst, mem_word(32'h4));
        issue_exit(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 32'h8);

        // Reset mid-FETCH, late ack during BOOT is dropped.
        reset = 1'b1;
        tick();
        check_eq("midrst_pc", pc, 32'h0);
        check_eq("midrst_req", {31'd0, imem_req}, 32'd0);
        check_eq("midrst_valid", {31'd0, inst_valid}, 32'd0);
        reset = 1'b0; imem_ack = 1'b1; imem_rdata = 32'hDEAD_BEEF;
        tick();
        check_eq("boot_ack_inst", inst, 32'h0000_0013);
        check_eq("boot_ack_pc", pc, 32'h0);
        check_eq("refetch_req", {31'd0, imem_req}, 32'd1);
        check_eq("refetch_addr", {18'd0, imem_addr}, 32'd0);
        imem_rdata = mem_word(32'h0);
        tick();
        imem_ack = 1'b0; imem_rdata = 32'h0;
        check_eq("refetch_valid", {31'd0, inst_valid}, 32'd1);
        check_eq("refetch_inst", inst, mem_word(32'h0));

        // Misaligned Jal target.
        Jal = 1'b1; imm32 = 32'h2;
        tick();
        Jal = 1'b0; imm32 = 32'h0;
`ifdef IFETCH_MISALIGN_TRAP_EN
        check_eq("trap_misalign", {31'd0, misalign}, 32'd1);
        check_eq("trap_pc", pc, 32'h0);
        check_eq("trap_valid", {31'd0, inst_valid}, 32'd0);
        imem_ack = 1'b1;
        for (int i = 0; i < 3; i++) begin
            check_eq("halt_req", {31'd0, imem_req}, 32'd0);
            check_eq("halt_misalign", {31'd0, misalign}, 32'd1);
            tick();
        end
        imem_ack = 1'b0;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check_eq("trap_rst_misalign", {31'd0, misalign}, 32'd0);
`else
        check_eq("force_align_pc", pc, 32'h0);
        check_eq("force_align_req", {31'd0, imem_req}, 32'd1);
        check_eq("force_align_misalign", {31'd0, misalign}, 32'd0);
        fetch(0, 32'h0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
